serial_pair_transmitter: RTL

Dual-channel parallel-to-serial transmitter that produces the two MSB-first bit streams (x, y) consumed by the team's serial comparator.
- Accepts a pair of WIDTH-bit operands through a start/ready handshake and buffers one pending pair.
- Emits a one-cycle frame_clear before each frame, then shifts both operands out one bit per clock.
- Flags the last bit of each frame and pulses done after it.

---
 rtl/serial_pkg.sv | 19 +
 rtl/serial_pair_transmitter_if.sv | 29 ++
 rtl/piso_shift_reg.sv | 40 ++++
 rtl/serial_pair_transmitter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial pair transmitter and its consumers.
//   state_e       : transmitter FSM states
//   WIDTH_DEFAULT : default operand width
//   cnt_width()   : bit counter width for a given operand width (minimum 1)
package serial_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_pair_transmitter_if.sv
// Operand handshake and serial output bundle of the serial pair transmitter.
//   start/a_in/b_in : operand pair request (driven by the producer)
//   ready           : holding register empty
//   x_out/y_out     : MSB-first serial bits of a and b
//   bit_valid, frame_clear, last_bit, done : frame framing strobes
interface serial_pair_transmitter_if #(
  parameter int unsigned WIDTH = serial_pkg::WIDTH_DEFAULT
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             ready;
  logic             x_out;
  logic             y_out;
  logic             bit_valid;
  logic             frame_clear;
  logic             last_bit;
  logic             done;

  modport master (
    output start, a_in, b_in,
    input  ready, x_out, y_out, bit_valid, frame_clear, last_bit, done
  );

  modport slave (
    input  start, a_in, b_in,
    output ready, x_out, y_out, bit_valid, frame_clear, last_bit, done
  );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-load, MSB-first shift register.
//   clk, rst_n : clock, synchronous active-low reset
//   load_i     : capture data_i (has priority over shift_i)
//   shift_i    : shift left by one, zero fill
//   data_i     : parallel load value
//   msb_o      : current most significant bit
module piso_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = sr_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_pair_transmitter.sv
// Dual-channel parallel-to-serial transmitter feeding the serial comparator.
// Buffers one pending operand pair, emits a one-cycle frame_clear, then
// shifts both operands out MSB first, flagging the last bit and pulsing done.
//   clk   : system clock
//   reset : synchronous active-low reset
//   bus   : operand handshake and serial outputs (slave side)
module serial_pair_transmitter
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  serial_pair_transmitter_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hold_full_q, hold_full_d;
  logic [WIDTH-1:0]   hold_a_q, hold_a_d;
  logic [WIDTH-1:0]   hold_b_q, hold_b_d;

  logic x_out_q, x_out_d;
  logic y_out_q, y_out_d;
  logic bit_valid_q, bit_valid_d;
  logic frame_clear_q, frame_clear_d;
  logic last_bit_q, last_bit_d;
  logic done_q, done_d;

  logic load;
  logic shift;
  logic a_msb;
  logic b_msb;

  piso_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (load),
    .shift_i(shift),
    .data_i (hold_a_q),
    .msb_o  (a_msb)
  );

  piso_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (load),
    .shift_i(shift),
    .data_i (hold_b_q),
    .msb_o  (b_msb)
  );

  // Next state, hold register and next registered outputs.
  // Output registers reflect the state being entered, so the shift register
  // MSB is sampled and shifted on the same edge that emits it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load        = 1'b0;
    shift       = 1'b0;
    done_d      = 1'b0;
    hold_full_d = hold_full_q;
    hold_a_d    = hold_a_q;
    hold_b_d    = hold_b_q;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d = CLEAR;
          load    = 1'b1;
        end
      end
      CLEAR: begin
        state_d = SHIFT;
        cnt_d   = CNT_W'(WIDTH - 1);
        shift   = 1'b1;
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
          if (hold_full_q) begin
            state_d = CLEAR;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          shift = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A transfer only happens while full, and accepts only while empty.
    if (load) begin
      hold_full_d = 1'b0;
    end else if (bus.start && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_a_d    = bus.a_in;
      hold_b_d    = bus.b_in;
    end

    frame_clear_d = (state_d == CLEAR);
    bit_valid_d   = (state_d == SHIFT);
    last_bit_d    = bit_valid_d && (cnt_d == '0);
    x_out_d       = bit_valid_d && a_msb;
    y_out_d       = bit_valid_d && b_msb;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hold_full_q   <= 1'b0;
      hold_a_q      <= '0;
      hold_b_q      <= '0;
      x_out_q       <= 1'b0;
      y_out_q       <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_clear_q <= 1'b0;
      last_bit_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_full_q   <= hold_full_d;
      hold_a_q      <= hold_a_d;
      hold_b_q      <= hold_b_d;
      x_out_q       <= x_out_d;
      y_out_q       <= y_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_clear_q <= frame_clear_d;
      last_bit_q    <= last_bit_d;
      done_q        <= done_d;
    end
  end

  assign bus.ready       = ~hold_full_q;
  assign bus.x_out       = x_out_q;
  assign bus.y_out       = y_out_q;
  assign bus.bit_valid   = bit_valid_q;
  assign bus.frame_clear = frame_clear_q;
  assign bus.last_bit    = last_bit_q;
  assign bus.done        = done_q;

endmodule
